// File: rtl/game_pkg.sv
// Shared screen, coordinate and sprite constants for the player bullet block
// and the enemy controllers.
package game_pkg;

  localparam int COORD_W      = 10;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int BULLET_COUNT = 8;
  localparam int PLAYER_W     = 32;
  localparam int PLAYER_H     = 32;
  localparam int BULLET_W     = 8;
  localparam int BULLET_H     = 8;
  localparam int ENEMY_W      = 32;
  localparam int ENEMY_H      = 32;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for the raw fire button.
// Emits a one-cycle pulse per press and never auto-repeats.
module button_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic       r_armed;
  logic [1:0] r_settle;

  // r_armed stays low until the synchronised button has been seen released
  // after reset, so a press held through reset release cannot fire.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_prev   <= 1'b0;
      r_armed  <= 1'b0;
      r_settle <= 2'b00;
    end else begin
      r_meta   <= i_btn;
      r_sync   <= r_meta;
      r_prev   <= r_sync;
      r_settle <= {r_settle[0], 1'b1};
      if (r_settle[1] && !r_sync) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_rise = r_sync & ~r_prev & r_armed;

endmodule

// File: rtl/player_bullet_controller.sv
// Player bullet pool: debounced fire with cooldown, lowest-free-slot spawn,
// periodic upward movement and per-slot hit consumption.
module player_bullet_controller #(
  parameter int BULLET_COUNT = game_pkg::BULLET_COUNT,
  parameter int MOVE_PERIOD  = 100_000,
  parameter int SPEED        = 4,
  parameter int COOLDOWN     = 2_500_000,
  parameter int SPAWN_DX     = 12,
  parameter int BULLET_H     = game_pkg::BULLET_H
) (
  input  logic                                    clk25,
  input  logic                                    rst,
  input  logic                                    fire_btn,
  input  logic [game_pkg::COORD_W-1:0]            player_x,
  input  logic [game_pkg::COORD_W-1:0]            player_y,
  input  logic [BULLET_COUNT-1:0]                 bullet_hit_flat,
  output logic [game_pkg::COORD_W*BULLET_COUNT-1:0] bullet_x_flat,
  output logic [game_pkg::COORD_W*BULLET_COUNT-1:0] bullet_y_flat,
  output logic [BULLET_COUNT-1:0]                 bullet_active_flat
);

  localparam int XW = game_pkg::COORD_W;
  localparam int TW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [XW-1:0] L_DX        = XW'(SPAWN_DX);
  localparam logic [XW-1:0] L_BH        = XW'(BULLET_H);
  localparam logic [XW-1:0] L_SPEED     = XW'(SPEED);
  localparam logic [TW-1:0] L_TICK_MAX  = TW'(MOVE_PERIOD - 1);
  localparam logic [CW-1:0] L_COOL_LOAD = CW'(COOLDOWN - 1);

  logic [XW-1:0]           r_x [BULLET_COUNT];
  logic [XW-1:0]           r_y [BULLET_COUNT];
  logic [BULLET_COUNT-1:0] r_active;
  logic [TW-1:0]           r_tick_cnt;
  logic [CW-1:0]           r_cool;

  logic                    w_fire_req;
  logic                    w_tick;
  logic                    w_free;
  logic                    w_shot;
  logic [BULLET_COUNT-1:0] w_claim;
  logic [XW-1:0]           w_spawn_x;
  logic [XW-1:0]           w_spawn_y;

  button_edge_sync u_fire_sync (
    .i_clk  (clk25),
    .i_rst  (rst),
    .i_btn  (fire_btn),
    .o_rise (w_fire_req)
  );

  // One-hot claim of the lowest-index slot that is inactive right now; slots
  // freed this cycle only become visible here on the next cycle.
  always_comb begin
    w_claim = '0;
    w_free  = 1'b0;
    for (int i = 0; i < BULLET_COUNT; i++) begin
      if (!r_active[i] && !w_free) begin
        w_claim[i] = 1'b1;
        w_free     = 1'b1;
      end
    end
  end

  assign w_tick    = (r_tick_cnt == L_TICK_MAX);
  assign w_shot    = w_fire_req && (r_cool == '0) && w_free && (player_y >= L_BH);
  assign w_spawn_x = player_x + L_DX;
  assign w_spawn_y = player_y - L_BH;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_cool <= '0;
    end else if (w_shot) begin
      r_cool <= L_COOL_LOAD;
    end else if (r_cool != '0) begin
      r_cool <= r_cool - CW'(1);
    end
  end

  // Per slot: hit wins, then spawn (only into an inactive slot), then move.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_active <= '0;
      for (int i = 0; i < BULLET_COUNT; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BULLET_COUNT; i++) begin
        if (bullet_hit_flat[i]) begin
          r_active[i] <= 1'b0;
        end else if (w_shot && w_claim[i]) begin
          r_active[i] <= 1'b1;
          r_x[i]      <= w_spawn_x;
          r_y[i]      <= w_spawn_y;
        end else if (w_tick && r_active[i]) begin
          if (r_y[i] < L_SPEED) begin
            r_active[i] <= 1'b0;
          end else begin
            r_y[i] <= r_y[i] - L_SPEED;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < BULLET_COUNT; g++) begin : g_flat
    assign bullet_x_flat[g*XW +: XW] = r_x[g];
    assign bullet_y_flat[g*XW +: XW] = r_y[g];
  end

  assign bullet_active_flat = r_active;

endmodule

// File: tb/tb_player_bullet_controller.sv
// Directed bench for player_bullet_controller with a short move period and
// cooldown so every scenario fits in a few hundred cycles.
module tb_player_bullet_controller;

  logic        clk25;
  logic        rst;
  logic        fire_btn;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic [7:0]  bullet_hit_flat;
  logic [79:0] bullet_x_flat;
  logic [79:0] bullet_y_flat;
  logic [7:0]  bullet_active_flat;

  int n_cmp = 0;
  int n_bad = 0;

  player_bullet_controller #(
    .BULLET_COUNT (8),
    .MOVE_PERIOD  (4),
    .SPEED        (4),
    .COOLDOWN     (8),
    .SPAWN_DX     (12),
    .BULLET_H     (8)
  ) dut (
    .clk25              (clk25),
    .rst                (rst),
    .fire_btn           (fire_btn),
    .player_x           (player_x),
    .player_y           (player_y),
    .bullet_hit_flat    (bullet_hit_flat),
    .bullet_x_flat      (bullet_x_flat),
    .bullet_y_flat      (bullet_y_flat),
    .bullet_active_flat (bullet_active_flat)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] sx(input int i);
    return bullet_x_flat[i*10 +: 10];
  endfunction

  function automatic logic [9:0] sy(input int i);
    return bullet_y_flat[i*10 +: 10];
  endfunction

  task automatic edges(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic btn_down();
    @(negedge clk25);
    fire_btn = 1'b1;
  endtask

  task automatic btn_up();
    @(negedge clk25);
    fire_btn = 1'b0;
  endtask

  // Returns on the negedge where rst drops; E1 is the following posedge.
  task automatic do_reset(input string tag);
    @(negedge clk25);
    rst = 1'b1;
    edges(2);
    check_eq({tag, "_rst_act"}, {72'd0, bullet_active_flat}, 80'd0);
    check_eq({tag, "_rst_x"}, bullet_x_flat, 80'd0);
    check_eq({tag, "_rst_y"}, bullet_y_flat, 80'd0);
    @(negedge clk25);
    rst = 1'b0;
  endtask

  logic [7:0] mask;

  initial begin
    rst             = 1'b1;
    fire_btn        = 1'b0;
    player_x        = 10'd300;
    player_y        = 10'd440;
    bullet_hit_flat = 8'h00;

    // Single press, exact latency, spawn coordinates, one move, no auto-repeat.
    do_reset("t1");
    edges(3);
    btn_down();
    edges(2);
    check_eq("lat_cycle2", {72'd0, bullet_active_flat}, 80'h00);
    edges(1);
    check_eq("lat_cycle3", {72'd0, bullet_active_flat}, 80'h01);
    check_eq("spawn_x", {70'd0, sx(0)}, 80'd312);
    check_eq("spawn_y", {70'd0, sy(0)}, 80'd432);
    edges(4);
    check_eq("move_y", {70'd0, sy(0)}, 80'd428);
    check_eq("move_x", {70'd0, sx(0)}, 80'd312);
    edges(93);
    btn_up();
    edges(5);
    check_eq("hold_one", {72'd0, bullet_active_flat}, 80'h01);

    // Second press inside cooldown dropped; later press lands in slot 1.
    do_reset("t2");
    edges(3);
    btn_down();
    edges(3);
    check_eq("cd_first", {72'd0, bullet_active_flat}, 80'h01);
    btn_up();
    edges(2);
    btn_down();
    edges(3);
    check_eq("cd_drop", {72'd0, bullet_active_flat}, 80'h01);
    btn_up();
    edges(10);
    btn_down();
    edges(3);
    check_eq("cd_expired", {72'd0, bullet_active_flat}, 80'h03);
    check_eq("cd_slot1_x", {70'd0, sx(1)}, 80'd312);
    btn_up();

    // Top-of-screen boundaries.
    do_reset("t3");
    edges(3);
    player_y = 10'd7;
    btn_down();
    edges(3);
    check_eq("y_too_low", {72'd0, bullet_active_flat}, 80'h00);
    btn_up();
    edges(2);
    player_y = 10'd8;
    btn_down();
    edges(3);
    check_eq("y_edge_act", {72'd0, bullet_active_flat}, 80'h01);
    check_eq("y_edge_y", {70'd0, sy(0)}, 80'd0);
    btn_up();
    edges(4);
    check_eq("y0_gone", {72'd0, bullet_active_flat}, 80'h00);
    player_y = 10'd15;
    edges(6);
    btn_down();
    edges(3);
    check_eq("y7_spawn", {70'd0, sy(0)}, 80'd7);
    btn_up();
    edges(4);
    check_eq("y3_y", {70'd0, sy(0)}, 80'd3);
    check_eq("y3_act", {72'd0, bullet_active_flat}, 80'h01);
    edges(4);
    check_eq("y3_gone", {72'd0, bullet_active_flat}, 80'h00);
    check_eq("y3_hold", {70'd0, sy(0)}, 80'd3);
    player_y = 10'd16;
    edges(6);
    btn_down();
    edges(3);
    check_eq("y8_spawn", {70'd0, sy(0)}, 80'd8);
    btn_up();
    edges(4);
    check_eq("y4_y", {70'd0, sy(0)}, 80'd4);
    edges(4);
    check_eq("y0_y", {70'd0, sy(0)}, 80'd0);
    check_eq("y0_act", {72'd0, bullet_active_flat}, 80'h01);
    edges(4);
    check_eq("y0_after", {72'd0, bullet_active_flat}, 80'h00);

    // Fill all slots, drop a press when full, hit slot 5, refill it at once.
    player_x = 10'd100;
    player_y = 10'd479;
    do_reset("t4");
    edges(3);
    mask = 8'h00;
    for (int k = 0; k < 8; k++) begin
      mask = {mask[6:0], 1'b1};
      btn_down();
      edges(3);
      check_eq($sformatf("fill_%0d", k), {72'd0, bullet_active_flat}, {72'd0, mask});
      btn_up();
      edges(10);
    end
    btn_down();
    edges(3);
    check_eq("full_drop", {72'd0, bullet_active_flat}, 80'hFF);
    btn_up();
    edges(1);
    @(negedge clk25);
    bullet_hit_flat = 8'h20;
    @(negedge clk25);
    bullet_hit_flat = 8'h00;
    edges(1);
    check_eq("hit5", {72'd0, bullet_active_flat}, 80'hDF);
    player_x = 10'd200;
    btn_down();
    edges(3);
    check_eq("refill_act", {72'd0, bullet_active_flat}, 80'hFF);
    check_eq("refill_x5", {70'd0, sx(5)}, 80'd212);
    check_eq("refill_y5", {70'd0, sy(5)}, 80'd471);
    btn_up();

    // Asynchronous reset with bullets in flight, then tick phase after release.
    @(negedge clk25);
    #2 rst = 1'b1;
    #1;
    check_eq("async_act", {72'd0, bullet_active_flat}, 80'd0);
    check_eq("async_x", bullet_x_flat, 80'd0);
    check_eq("async_y", bullet_y_flat, 80'd0);
    edges(2);
    @(negedge clk25);
    rst = 1'b0;
    edges(3);
    btn_down();
    edges(3);
    check_eq("post_rst_fire", {72'd0, bullet_active_flat}, 80'h01);
    check_eq("post_rst_y", {70'd0, sy(0)}, 80'd471);
    edges(1);
    check_eq("tick_phase_hold", {70'd0, sy(0)}, 80'd471);
    edges(1);
    check_eq("tick_phase_move", {70'd0, sy(0)}, 80'd467);
    btn_up();

    // Button held through reset release must not fire until re-pressed.
    fire_btn = 1'b1;
    do_reset("t6");
    edges(20);
    check_eq("held_no_fire", {72'd0, bullet_active_flat}, 80'h00);
    btn_up();
    edges(3);
    btn_down();
    edges(3);
    check_eq("repress_fire", {72'd0, bullet_active_flat}, 80'h01);
    btn_up();
    edges(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/player_bullet_controller.md
PLAYER_BULLET_CONTROLLER -- requirements
Module: player_bullet_controller

Interface
REQ-001 SHALL have parameter BULLET_COUNT, default 8, number of bullet slots; downstream consumers expect 8.
REQ-002 SHALL have parameter MOVE_PERIOD, default 100_000, clk25 cycles between movement ticks.
REQ-003 SHALL have parameter SPEED, default 4, pixels moved upward per tick.
REQ-004 SHALL have parameter COOLDOWN, default 2_500_000, minimum clk25 cycles between accepted shots.
REQ-005 SHALL have parameter SPAWN_DX, default 12, x offset from player_x (centres an 8-px bullet on a 32-px player).
REQ-006 SHALL have parameter BULLET_H, default 8, bullet height in pixels.
REQ-007 clk25  input  1  25 MHz system clock; one clock domain, all state on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 fire_btn  input  1  raw, unsynchronised fire button (high = pressed).
REQ-010 player_x  input  10  player sprite left edge, pixels.
REQ-011 player_y  input  10  player sprite top edge, pixels.
REQ-012 bullet_hit_flat  input  BULLET_COUNT  per-slot consume pulse from enemy collision logic.
REQ-013 bullet_x_flat  output  10*BULLET_COUNT  slot i x at [i*10 +: 10].
REQ-014 bullet_y_flat  output  10*BULLET_COUNT  slot i y at [i*10 +: 10].
REQ-015 bullet_active_flat  output  BULLET_COUNT  slot i live when bit i = 1.

Function
REQ-016 fire_btn SHALL pass a 2-FF synchroniser and then a rising-edge detector; one press SHALL yield one fire request, and holding the button SHALL NOT auto-repeat.
REQ-017 A cooldown counter SHALL load COOLDOWN-1 on each accepted shot and count down to 0; a fire request SHALL be accepted only when the counter is 0.
REQ-018 If fire is accepted, it SHALL occupy the lowest-index inactive slot with x = player_x + SPAWN_DX and y = player_y - BULLET_H, and set its active bit on the next edge.
REQ-019 Fire SHALL be dropped (no spawn, cooldown not loaded) when all slots are active or when player_y < BULLET_H.
REQ-020 Latency SHALL be 3 cycles from fire_btn rising (meeting setup) to bullet_active_flat bit set.
REQ-021 A tick counter SHALL count 0..MOVE_PERIOD-1 and wrap; tick SHALL assert for one cycle on the wrap.
REQ-022 On tick, each active slot SHALL deactivate if y < SPEED; otherwise y SHALL decrease by SPEED; x SHALL NOT change.
REQ-023 A slot with bullet_hit_flat[i]=1 SHALL deactivate on the next edge; hit SHALL take priority over move and spawn for that slot.
REQ-024 A slot spawned in a tick cycle SHALL NOT move that cycle; a slot freed by hit or tick in a cycle SHALL NOT be reused until the following cycle.
REQ-025 Inactive slots SHALL hold their last x/y; consumers SHALL qualify x/y with the active bit.
REQ-026 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 While rst=1, all active bits, x, y, the synchroniser/edge flops, the tick counter and the cooldown counter SHALL be 0.
REQ-028 Assertion of rst mid-flight SHALL clear all bullets immediately; after release, the first tick SHALL occur MOVE_PERIOD cycles later and fire SHALL be accepted at once (cooldown 0).
REQ-029 A button held through rst release SHALL NOT fire until it is released and pressed again.

Structure
REQ-030 Shared package game_pkg SHALL hold COORD_W=10, SCREEN_W=640, SCREEN_H=480, BULLET_COUNT, and sprite sizes, for use by this block and the enemy controllers.
REQ-031 The synchroniser and edge detector SHALL form one sub-module, button_edge_sync; slot update and lowest-free-slot priority encoder SHALL stay in the top.

Verification (MOVE_PERIOD=4, COOLDOWN=8, SPEED=4)
REQ-032 player_x=300, player_y=440, single press -> slot 0 active at x=312, y=432 three cycles later; y=428 after the next tick.
REQ-033 Press held 100 cycles -> exactly one bullet spawns.
REQ-034 Press twice 3 cycles apart -> second press ignored; press again after cooldown expires -> slot 1 spawns.
REQ-035 Bullet at y=3 on tick -> deactivated, y holds 3; bullet at y=4 -> y=0 and still active, then deactivated on the next tick.
REQ-036 All 8 slots active plus a press -> no change and cooldown stays 0; pulse bullet_hit_flat[5] -> slot 5 clears, next press refills slot 5.
REQ-037 Assert rst with 5 bullets live -> all outputs 0 within the same cycle, asynchronously.
